// File: rtl/uniq_track_arbiter.sv
// Round-robin arbiter sharing one unique-value tracker among requesters.
// Issues one value per cycle, returns tagged hit/miss, sequences flushes.
module uniq_track_arbiter #(
    parameter int DATA_W  = 8,
    parameter int N_REQ   = 4,
    parameter int DEPTH   = 4,
    parameter int TRK_LAT = 2,
    parameter int CLR_CYC = 2,
    localparam int ID_W   = $clog2(N_REQ)
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic [N_REQ-1:0]        req_valid_in,
    input  logic [N_REQ*DATA_W-1:0] req_data_in,
    output logic [N_REQ-1:0]        req_ready_out,
    input  logic                    flush_in,
    output logic                    trk_valid_out,
    output logic [DATA_W-1:0]       trk_data_out,
    output logic                    trk_clear_out,
    input  logic [DEPTH*DATA_W-1:0] trk_entry_in,
    input  logic [DEPTH-1:0]        trk_entry_valid_in,
    output logic                    rsp_valid_out,
    output logic [ID_W-1:0]         rsp_id_out,
    output logic                    rsp_hit_out,
    output logic                    busy_out
);

    localparam int CW = $clog2(CLR_CYC + 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYC - 1);

    typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;

    state_t             state;
    logic [CW-1:0]      clr_cnt;
    logic [ID_W-1:0]    ptr;
    logic [ID_W:0]      idx;
    logic [ID_W-1:0]    win;
    logic [ID_W-1:0]    nxt_ptr;
    logic               found;
    logic               grant_en;
    logic               xfer;
    logic               hit;
    logic               inflight;
    logic [DATA_W-1:0]  win_data;
    logic [TRK_LAT-1:0] pv;
    logic [ID_W-1:0]    pid  [TRK_LAT];
    logic [DATA_W-1:0]  pdat [TRK_LAT];

    // First valid requester at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = {1'b0, ptr} + (ID_W+1)'(i);
            if (idx >= (ID_W+1)'(N_REQ))
                idx = idx - (ID_W+1)'(N_REQ);
            if (!found && req_valid_in[idx[ID_W-1:0]]) begin
                found = 1'b1;
                win   = idx[ID_W-1:0];
            end
        end
    end

    assign grant_en = reset_in && (state == RUN) && !flush_in;
    assign xfer     = grant_en && found;
    assign win_data = req_data_in[win*DATA_W +: DATA_W];
    assign nxt_ptr  = (win == ID_W'(N_REQ - 1)) ? '0 : win + 1'b1;
    assign inflight = |pv;
    assign busy_out = (state != RUN);

    always_comb begin
        req_ready_out = '0;
        if (xfer)
            req_ready_out[win] = 1'b1;
    end

    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < DEPTH; k++)
            if (trk_entry_valid_in[k] &&
                trk_entry_in[k*DATA_W +: DATA_W] == pdat[TRK_LAT-1])
                hit = 1'b1;
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            ptr           <= '0;
            trk_valid_out <= 1'b0;
            trk_data_out  <= '0;
            pv            <= '0;
            rsp_valid_out <= 1'b0;
            rsp_id_out    <= '0;
            rsp_hit_out   <= 1'b0;
            for (int i = 0; i < TRK_LAT; i++) begin
                pid[i]  <= '0;
                pdat[i] <= '0;
            end
        end else begin
            trk_valid_out <= xfer;
            if (xfer) begin
                ptr          <= nxt_ptr;
                trk_data_out <= win_data;
            end
            pv[0]   <= xfer;
            pid[0]  <= win;
            pdat[0] <= win_data;
            for (int i = 1; i < TRK_LAT; i++) begin
                pv[i]   <= pv[i-1];
                pid[i]  <= pid[i-1];
                pdat[i] <= pdat[i-1];
            end
            rsp_valid_out <= pv[TRK_LAT-1];
            rsp_id_out    <= pid[TRK_LAT-1];
            rsp_hit_out   <= pv[TRK_LAT-1] && hit;
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state         <= RUN;
            clr_cnt       <= '0;
            trk_clear_out <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (flush_in)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (!inflight) begin
                        state         <= CLEAR;
                        trk_clear_out <= 1'b1;
                        clr_cnt       <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_cnt == CLR_LAST) begin
                        state         <= RUN;
                        trk_clear_out <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: begin
                    state         <= RUN;
                    trk_clear_out <= 1'b0;
                end
            endcase
        end
    end

endmodule
